// File: rtl/mips_pc_fetch_unit.sv
// PC, instruction/data registers and memory wait handling for a multicycle MIPS core.
// Optional performance counters are built when MIPS_PERF_CNT_EN is defined.
module mips_pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        Branch,
  input  logic        BranchNE,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic        MemWrite,
  input  logic [1:0]  PCSrc,
  input  logic        Zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [31:0] data,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] instr_count,
  output logic [31:0] branch_count
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ABANDON = 2'd2
  } wait_state_e;

  wait_state_e      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      data_q, data_d;
  logic             addr_err_q, addr_err_d;
  logic             bus_err_q, bus_err_d;

  logic [31:0]      addr_raw;
  logic [31:0]      rdata_eff;
  logic [31:0]      pc_next;
  logic             access_done;
  logic             abandon_done;
  logic             ir_load;
  logic             taken;
  logic             pc_en;

  // Memory request is suppressed while reset is held so no access leaks out.
  assign mem_req  = reset & (IRWrite | IorD | MemWrite);
  assign mem_we   = reset & MemWrite;
  assign addr_raw = IorD ? alu_out : pc_q;
  assign mem_addr = {addr_raw[31:2], 2'b00};

  assign stall        = mem_req & ~mem_ready & (state_q != ABANDON);
  assign abandon_done = mem_req & (state_q == ABANDON);
  assign access_done  = mem_req & (mem_ready | (state_q == ABANDON));
  assign rdata_eff    = abandon_done ? 32'h0 : mem_rdata;
  assign ir_load      = access_done & IRWrite;

  assign taken = Branch & (BranchNE ? ~Zero : Zero);
  assign pc_en = (PCWrite & ~stall) | taken;

  // Wait-state tracking: count stalled cycles and give up after TIMEOUT of them.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (mem_req & ~mem_ready) state_d = WAIT;
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (mem_ready | ~mem_req) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_d == CNT_W'(TIMEOUT - 1)) begin
          state_d = ABANDON;
        end
      end
      ABANDON: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
      default: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // Next-PC selection and register load enables.
  always_comb begin
    pc_next = pc_q;
    case (PCSrc)
      2'b00:   pc_next = alu_result;
      2'b01:   pc_next = alu_out;
      2'b10:   pc_next = {pc_q[31:28], instr_q[25:0], 2'b00};
      default: pc_next = pc_q;
    endcase

    pc_d       = pc_en ? pc_next : pc_q;
    instr_d    = ir_load ? rdata_eff : instr_q;
    data_d     = (access_done & IorD & ~MemWrite) ? rdata_eff : data_q;
    addr_err_d = addr_err_q | (mem_req & (addr_raw[1:0] != 2'b00));
    bus_err_d  = bus_err_q | abandon_done;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      data_q     <= 32'h0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      data_q     <= data_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign pc       = pc_q;
  assign instr    = instr_q;
  assign data     = data_q;
  assign opcode   = instr_q[31:26];
  assign funct    = instr_q[5:0];
  assign addr_err = addr_err_q;
  assign bus_err  = bus_err_q;

`ifdef MIPS_PERF_CNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic [31:0] branch_count_q, branch_count_d;

  // Free-running event counters; they wrap naturally at 2^32.
  always_comb begin
    instr_count_d  = instr_count_q + 32'(ir_load);
    branch_count_d = branch_count_q + 32'(taken);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_count_q  <= 32'h0;
      branch_count_q <= 32'h0;
    end else begin
      instr_count_q  <= instr_count_d;
      branch_count_q <= branch_count_d;
    end
  end

  assign instr_count  = instr_count_q;
  assign branch_count = branch_count_q;
`else
  assign instr_count  = 32'h0;
  assign branch_count = 32'h0;
`endif

endmodule

// File: tb/tb_mips_pc_fetch_unit.sv
// Table-driven bench for mips_pc_fetch_unit with a queue of post-edge expectations.
module tb_mips_pc_fetch_unit;

`ifdef MIPS_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        PCWrite, Branch, BranchNE, IorD, IRWrite, MemWrite, Zero;
  logic [1:0]  PCSrc;
  logic [31:0] alu_result, alu_out, mem_rdata;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_req, mem_we;
  logic [31:0] pc, instr, data;
  logic [5:0]  opcode, funct;
  logic        stall, addr_err, bus_err;
  logic [31:0] instr_count, branch_count;

  mips_pc_fetch_unit dut (
    .clock(clock), .reset(reset),
    .PCWrite(PCWrite), .Branch(Branch), .BranchNE(BranchNE), .IorD(IorD),
    .IRWrite(IRWrite), .MemWrite(MemWrite), .PCSrc(PCSrc), .Zero(Zero),
    .alu_result(alu_result), .alu_out(alu_out), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_we(mem_we), .pc(pc), .instr(instr), .data(data), .opcode(opcode),
    .funct(funct), .stall(stall), .addr_err(addr_err), .bus_err(bus_err),
    .instr_count(instr_count), .branch_count(branch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ctl = {IRWrite, PCWrite, IorD, MemWrite, Branch, BranchNE, Zero}
  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [1:0]  src;
    logic [31:0] ar;
    logic [31:0] ao;
    logic        rdy;
    logic [31:0] rd;
    logic        st;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] dat;
    logic        ae;
    logic        be;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] dat;
    logic        ae;
    logic        be;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[15];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [6:0] ctl, input logic [1:0] src,
                              input logic [31:0] ar, input logic [31:0] ao, input logic rdy,
                              input logic [31:0] rd, input logic st, input logic [31:0] addr,
                              input logic [31:0] pcv, input logic [31:0] ins,
                              input logic [31:0] dat, input logic ae, input logic be);
    vec_t v;
    v.name = nm; v.ctl = ctl; v.src = src; v.ar = ar; v.ao = ao; v.rdy = rdy; v.rd = rd;
    v.st = st; v.addr = addr; v.pc = pcv; v.ins = ins; v.dat = dat; v.ae = ae; v.be = be;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    {IRWrite, PCWrite, IorD, MemWrite, Branch, BranchNE, Zero} = v.ctl;
    PCSrc = v.src; alu_result = v.ar; alu_out = v.ao; mem_ready = v.rdy; mem_rdata = v.rd;
  endtask

  // One clock: drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clock);
    drive(v);
    #1;
    chk({v.name, ":stall"}, 32'(stall), 32'(v.st));
    chk({v.name, ":mem_req"}, 32'(mem_req), 32'(v.ctl[6] | v.ctl[4] | v.ctl[3]));
    chk({v.name, ":mem_we"}, 32'(mem_we), 32'(v.ctl[3]));
    chk({v.name, ":mem_addr"}, mem_addr, v.addr);
    e.name = v.name; e.pc = v.pc; e.ins = v.ins; e.dat = v.dat; e.ae = v.ae; e.be = v.be;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk({e.name, ":pc"}, pc, e.pc);
    chk({e.name, ":instr"}, instr, e.ins);
    chk({e.name, ":opcode"}, 32'(opcode), 32'(e.ins[31:26]));
    chk({e.name, ":funct"}, 32'(funct), 32'(e.ins[5:0]));
    chk({e.name, ":data"}, data, e.dat);
    chk({e.name, ":addr_err"}, 32'(addr_err), 32'(e.ae));
    chk({e.name, ":bus_err"}, 32'(bus_err), 32'(e.be));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    tbl[0]  = mk("fetch0",      7'b1100000, 2'b00, 32'h4,         32'h0,   1'b1, 32'h2008_0005, 1'b0, 32'h0,         32'h4,         32'h2008_0005, 32'h0,         1'b0, 1'b0);
    tbl[1]  = mk("wait1",       7'b1100000, 2'b00, 32'h8,         32'h0,   1'b0, 32'h0,         1'b1, 32'h4,         32'h4,         32'h2008_0005, 32'h0,         1'b0, 1'b0);
    tbl[2]  = mk("wait2",       7'b1100000, 2'b00, 32'h8,         32'h0,   1'b0, 32'h0,         1'b1, 32'h4,         32'h4,         32'h2008_0005, 32'h0,         1'b0, 1'b0);
    tbl[3]  = mk("wait3",       7'b1100000, 2'b00, 32'h8,         32'h0,   1'b0, 32'h0,         1'b1, 32'h4,         32'h4,         32'h2008_0005, 32'h0,         1'b0, 1'b0);
    tbl[4]  = mk("wait_done",   7'b1100000, 2'b00, 32'h8,         32'h0,   1'b1, 32'h0109_5020, 1'b0, 32'h4,         32'h8,         32'h0109_5020, 32'h0,         1'b0, 1'b0);
    tbl[5]  = mk("beq_taken",   7'b0000101, 2'b01, 32'h0,         32'h40,  1'b0, 32'h0,         1'b0, 32'h8,         32'h40,        32'h0109_5020, 32'h0,         1'b0, 1'b0);
    tbl[6]  = mk("bne_not",     7'b0000111, 2'b01, 32'h0,         32'h80,  1'b0, 32'h0,         1'b0, 32'h40,        32'h40,        32'h0109_5020, 32'h0,         1'b0, 1'b0);
    tbl[7]  = mk("fetch_j",     7'b1100000, 2'b00, 32'h1000_0000, 32'h0,   1'b1, 32'h0800_0010, 1'b0, 32'h40,        32'h1000_0000, 32'h0800_0010, 32'h0,         1'b0, 1'b0);
    tbl[8]  = mk("jump",        7'b0100000, 2'b10, 32'h0,         32'h0,   1'b0, 32'h0,         1'b0, 32'h1000_0000, 32'h1000_0040, 32'h0800_0010, 32'h0,         1'b0, 1'b0);
    tbl[9]  = mk("misalign_ld", 7'b0010000, 2'b00, 32'h0,         32'h6,   1'b1, 32'hDEAD_BEEF, 1'b0, 32'h4,         32'h1000_0040, 32'h0800_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tbl[10] = mk("store",       7'b0011000, 2'b00, 32'h0,         32'h100, 1'b1, 32'h1111_1111, 1'b0, 32'h100,       32'h1000_0040, 32'h0800_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tbl[11] = mk("pcw_taken",   7'b0100101, 2'b00, 32'h200,       32'h0,   1'b0, 32'h0,         1'b0, 32'h1000_0040, 32'h200,       32'h0800_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tbl[12] = mk("taken_stall", 7'b1000101, 2'b01, 32'h0,         32'h300, 1'b0, 32'h0,         1'b1, 32'h200,       32'h300,       32'h0800_0010, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tbl[13] = mk("stall_done",  7'b1000000, 2'b11, 32'h0,         32'h0,   1'b1, 32'h0000_0008, 1'b0, 32'h300,       32'h300,       32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 1'b0);
    tbl[14] = mk("hold",        7'b0100000, 2'b11, 32'h0,         32'h0,   1'b0, 32'h0,         1'b0, 32'h300,       32'h300,       32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Reset state, with strobes raised to show the request is blocked during reset.
    reset = 1'b0;
    drive(mk("rst", 7'b1011000, 2'b00, 32'h0, 32'h7, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst:pc", pc, 32'h0);
    chk("rst:instr", instr, 32'h0);
    chk("rst:data", data, 32'h0);
    chk("rst:errs", 32'({addr_err, bus_err}), 32'h0);
    chk("rst:mem_req", 32'(mem_req), 32'h0);
    chk("rst:mem_we", 32'(mem_we), 32'h0);
    chk("rst:counts", instr_count | branch_count, 32'h0);
    drive(mk("idle", 7'b0, 2'b11, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(tbl[i]);
      if (i == 5) chk("branch_count_after_beq", branch_count, PERF ? 32'd1 : 32'd0);
    end
    chk("instr_count_table", instr_count, PERF ? 32'd4 : 32'd0);
    chk("branch_count_table", branch_count, PERF ? 32'd3 : 32'd0);

    // Timeout: sixteen stalled cycles, then the access is abandoned with zero data.
    for (int k = 0; k < 16; k++)
      step(mk($sformatf("tmo%0d", k), 7'b1000000, 2'b00, 32'h0, 32'h0, 1'b0, 32'h5555_5555, 1'b1,
              32'h300, 32'h300, 32'h0000_0008, 32'hDEAD_BEEF, 1'b1, 1'b0));
    step(mk("tmo_abandon", 7'b1000000, 2'b00, 32'h0, 32'h0, 1'b0, 32'h5555_5555, 1'b0,
            32'h300, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1));
    for (int k = 0; k < 2; k++)
      step(mk($sformatf("tmo_sticky%0d", k), 7'b0000000, 2'b11, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0,
              32'h300, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1));
    chk("instr_count_tmo", instr_count, PERF ? 32'd5 : 32'd0);

    // Reset mid-wait: the pending access must not load anything or flag an error.
    for (int k = 0; k < 3; k++)
      step(mk($sformatf("rstw%0d", k), 7'b1000000, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1,
              32'h300, 32'h300, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b1));
    @(negedge clock);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    reset = 1'b0;
    #1;
    chk("rstw:mem_req", 32'(mem_req), 32'h0);
    chk("rstw:pc", pc, 32'h0);
    chk("rstw:errs", 32'({addr_err, bus_err}), 32'h0);
    @(posedge clock);
    #1;
    chk("rstw:instr", instr, 32'h0);
    chk("rstw:data", data, 32'h0);
    chk("rstw:counts", instr_count | branch_count, 32'h0);
    @(negedge clock);
    v = mk("idle", 7'b0, 2'b11, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(v);
    reset = 1'b1;

    step(mk("refetch", 7'b1100000, 2'b00, 32'h4, 32'h0, 1'b1, 32'h2008_0005, 1'b0,
            32'h0, 32'h4, 32'h2008_0005, 32'h0, 1'b0, 1'b0));
    chk("instr_count_refetch", instr_count, PERF ? 32'd1 : 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_pc_fetch_unit.md
MIPS_PC_FETCH_UNIT -- requirements
Module: mips_pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum number of consecutive wait cycles before an access is abandoned.
REQ-003 SHALL have ports as listed, one per line, in the form name, direction, width, meaning:
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- PCWrite, Branch, BranchNE, IorD, IRWrite, MemWrite, in, 1 each: control strobes from the multicycle control FSM.
- PCSrc, in, 2: next-PC select.
- Zero, in, 1: ALU zero flag.
- alu_result, in, 32: combinational ALU output.
- alu_out, in, 32: registered ALU output.
- mem_rdata, in, 32: memory read data.
- mem_ready, in, 1: memory completes the access this cycle.
- mem_addr, out, 32: memory address.
- mem_req, out, 1: access request.
- mem_we, out, 1: write request.
- pc, out, 32: program counter.
- instr, out, 32: instruction register.
- data, out, 32: memory data register.
- opcode, out, 6: instr[31:26].
- funct, out, 6: instr[5:0].
- stall, out, 1: FSM must hold its state.
- addr_err, out, 1: sticky misalignment flag.
- bus_err, out, 1: sticky timeout flag.
- instr_count, out, 32: performance counter.
- branch_count, out, 32: performance counter.

Function
REQ-004 SHALL drive mem_req = IRWrite | IorD | MemWrite and mem_we = MemWrite, combinationally.
REQ-005 SHALL drive mem_addr = IorD ? alu_out : pc, with bits [1:0] forced to 2'b00.
REQ-006 SHALL set addr_err on any cycle where mem_req = 1 and the unforced address[1:0] != 0; the access SHALL still proceed.
REQ-007 SHALL drive stall = mem_req & ~mem_ready & (wait state is not ABANDON).
REQ-008 SHALL implement a wait FSM with states IDLE, WAIT and ABANDON:
- IDLE->WAIT on mem_req & ~mem_ready.
- WAIT->IDLE on mem_ready or on mem_req falling.
- WAIT->ABANDON when the wait counter reaches TIMEOUT-1.
- ABANDON->IDLE unconditionally after one cycle.
REQ-009 SHALL clear the wait counter in IDLE and increment it in WAIT.
REQ-010 SHALL treat an access as complete when mem_req & (mem_ready | state == ABANDON); on an ABANDON completion, read data SHALL be taken as 32'h0 and bus_err SHALL set.
REQ-011 SHALL load instr on a completed access with IRWrite = 1, one-cycle latency after completion.
REQ-012 SHALL load data on a completed access with IorD = 1 and MemWrite = 0.
REQ-013 SHALL compute taken = Branch & (BranchNE ? ~Zero : Zero).
REQ-014 SHALL select next PC by PCSrc:
- 00: alu_result.
- 01: alu_out.
- 10: {pc[31:28], instr[25:0], 2'b00}.
- 11: hold pc.
REQ-015 SHALL update pc on a rising edge when (PCWrite & ~stall) | taken.
REQ-016 SHALL give PCWrite and taken asserted in the same cycle a single PC update.
REQ-017 SHALL treat a 32-bit PC overflow as wrap-around modulo 2^32.
REQ-018 SHALL take opcode and funct from the registered instr only.

Reset
REQ-019 SHALL, on reset low, asynchronously set:
- pc = RESET_PC.
- instr, data, instr_count and branch_count = 0.
- addr_err and bus_err = 0.
- wait FSM = IDLE, counter = 0.
REQ-020 SHALL, on reset asserted mid-WAIT, abandon the access with no instr/data load and no bus_err.
REQ-021 SHALL drive mem_req and mem_we to 0 while reset is low.
REQ-022 SHALL clear addr_err and bus_err only by reset.

Configuration
REQ-023 SHALL provide macro MIPS_PERF_CNT_EN with the following behaviour:
- Defined: instr_count increments on each instr load and branch_count increments on each cycle with taken = 1; both wrap from 32'hFFFF_FFFF to 0.
- Undefined: no counter registers are built and both outputs are tied to 32'h0.

Verification
REQ-024 Zero-wait fetch: reset release, IRWrite = PCWrite = 1, PCSrc = 00, alu_result = 4, mem_ready = 1, mem_rdata = 32'h2008_0005 -> next cycle pc = 4, instr = 32'h2008_0005, opcode = 6'b001000, stall = 0.
REQ-025 Wait states: IRWrite = 1 with mem_ready low for 3 cycles -> stall high for 3 cycles, pc unchanged; ready on the 4th cycle -> instr loaded, pc updated once.
REQ-026 Timeout: IRWrite = 1 with mem_ready held 0 (TIMEOUT = 16) -> stall drops after 16 cycles, instr = 0, bus_err = 1 until reset.
REQ-027 Branches:
- Branch = 1, BranchNE = 0, Zero = 1, PCSrc = 01, alu_out = 32'h40 -> pc = 32'h40.
- Same with BranchNE = 1 -> pc unchanged.
- With MIPS_PERF_CNT_EN defined -> branch_count = 1.
REQ-028 Jump and misalignment:
- pc = 32'h1000_0000, instr[25:0] = 26'h10, PCSrc = 10, PCWrite = 1 -> pc = 32'h1000_0040.
- IorD = 1, alu_out = 32'h0000_0006 -> mem_addr = 32'h4, addr_err = 1.
